// File: rtl/pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_sequencer
//  Description : Loadable instruction store that issues one 46-bit ALU
//                instruction per clock for the current pixel, walks the
//                raster (x, y, frame) and flags completed pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int PROG_AW    = 4,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [45:0]        prog_data,
    input  logic [PROG_AW:0]   prog_length,
    input  logic               run,
    input  logic               hold,
    output logic [45:0]        instruction,
    output logic [31:0]        x_coord,
    output logic [31:0]        y_coord,
    output logic [31:0]        f_number,
    output logic               pixel_valid,
    output logic               frame_first,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // dest=4 is a register the ALU discards, so this word has no effect.
    localparam logic [45:0] c_nop    = {3'b100, 43'd0};
    localparam logic [31:0] c_x_last = 32'(WIDTH - 1);
    localparam logic [31:0] c_y_last = 32'(HEIGHT - 1);

    logic [45:0]        mem [PROG_DEPTH];

    state_t             state_q, state_d;
    logic [PROG_AW-1:0] pc_q, pc_d;
    logic [PROG_AW:0]   len_q, len_d;
    logic [31:0]        x_q, x_d;
    logic [31:0]        y_q, y_d;
    logic [31:0]        f_q, f_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic               frame_first_q, frame_first_d;
    logic               last_instr;

    // Instruction store: writable only while idle so a running program is never disturbed.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == ST_IDLE)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign last_instr = ({1'b0, pc_q} == (len_q - 1'b1));

    // Next-state logic: program counter, raster walk and completion flags.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        len_d         = len_q;
        x_d           = x_q;
        y_d           = y_q;
        f_d           = f_q;
        pixel_valid_d = 1'b0;
        frame_first_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run && (prog_length != '0)) begin
                    len_d   = prog_length;
                    pc_d    = '0;
                    state_d = hold ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_instr) begin
                    pc_d          = '0;
                    pixel_valid_d = 1'b1;
                    frame_first_d = (x_q == 32'd0) && (y_q == 32'd0);
                    if (x_q == c_x_last) begin
                        x_d = '0;
                        if (y_q == c_y_last) begin
                            y_d = '0;
                            f_d = f_q + 32'd1;
                        end else begin
                            y_d = y_q + 32'd1;
                        end
                    end else begin
                        x_d = x_q + 32'd1;
                    end
                    // Run and hold only matter once the pixel in flight is finished.
                    if (!run) begin
                        state_d = ST_IDLE;
                    end else if (hold) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_HOLD: begin
                pc_d = '0;
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any pixel in flight without flagging it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            f_q           <= '0;
            pixel_valid_q <= 1'b0;
            frame_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            x_q           <= x_d;
            y_q           <= y_d;
            f_q           <= f_d;
            pixel_valid_q <= pixel_valid_d;
            frame_first_q <= frame_first_d;
        end
    end

    assign instruction = (state_q == ST_RUN) ? mem[pc_q] : c_nop;
    assign x_coord     = x_q;
    assign y_coord     = y_q;
    assign f_number    = f_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_first = frame_first_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_sequencer
//  Description : Self-checking bench for pixel_sequencer on a 4x2 raster,
//                compared against a pixel-count based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_sequencer;

    localparam int W = 4;
    localparam int H = 2;
    localparam logic [45:0] NOP = {3'b100, 43'd0};

    logic        clk;
    logic        reset_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [45:0] prog_data;
    logic [4:0]  prog_length;
    logic        run;
    logic        hold;
    logic [45:0] instruction;
    logic [31:0] x_coord, y_coord, f_number;
    logic        pixel_valid, frame_first, busy;
    logic [144:0] obs;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: the raster position is derived from a count of completed pixels.
    logic [45:0]     m_mem [16];
    int              m_mode;   // 0 idle, 1 issuing, 2 holding
    int              m_len;
    int              m_step;
    longint unsigned m_pix;
    logic            m_valid, m_first;

    pixel_sequencer #(
        .PROG_DEPTH(16),
        .PROG_AW   (4),
        .WIDTH     (W),
        .HEIGHT    (H)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_length(prog_length),
        .run        (run),
        .hold       (hold),
        .instruction(instruction),
        .x_coord    (x_coord),
        .y_coord    (y_coord),
        .f_number   (f_number),
        .pixel_valid(pixel_valid),
        .frame_first(frame_first),
        .busy       (busy)
    );

    assign obs = {instruction, x_coord, y_coord, f_number, pixel_valid, frame_first, busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void model_reset();
        m_mode  = 0;
        m_len   = 0;
        m_step  = 0;
        m_pix   = 0;
        m_valid = 1'b0;
        m_first = 1'b0;
    endfunction

    function automatic logic [144:0] model_out();
        logic [45:0]     ins;
        longint unsigned fr;
        ins = (m_mode == 1) ? m_mem[m_step] : NOP;
        fr  = m_pix / (W * H);
        return {ins, 32'(m_pix % W), 32'((m_pix / W) % H), fr[31:0],
                m_valid, m_first, (m_mode != 0)};
    endfunction

    // Advance the model with the inputs presented to this edge, then clock the DUT.
    task automatic tick();
        if (reset_n) begin
            m_valid = 1'b0;
            m_first = 1'b0;
            case (m_mode)
                0: begin
                    if (prog_we) m_mem[prog_addr] = prog_data;
                    if (run && prog_length != 0) begin
                        m_len  = prog_length;
                        m_step = 0;
                        m_mode = hold ? 2 : 1;
                    end
                end
                1: begin
                    if (m_step == m_len - 1) begin
                        m_valid = 1'b1;
                        m_first = (m_pix % (W * H) == 0);
                        m_pix++;
                        m_step = 0;
                        m_mode = !run ? 0 : (hold ? 2 : 1);
                    end else begin
                        m_step++;
                    end
                end
                default: begin
                    if (!run) m_mode = 0;
                    else if (!hold) m_mode = 1;
                end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        run = 1'b0; hold = 1'b0; prog_we = 1'b0; reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        run = 1'b0; hold = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; prog_length = 5'd1; reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs !== model_out()) begin
            miscompares++;
            $display("FAIL reset_async got=%h exp=%h", obs, model_out());
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        vectors++;
        if (obs !== model_out()) begin
            miscompares++;
            $display("FAIL reset_release got=%h exp=%h", obs, model_out());
        end
    endtask

    task automatic test_load();
        for (int a = 0; a < 16; a++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(a);
            prog_data = {14'($urandom()), $urandom()};
            tick();
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL load a=%0d got=%h exp=%h", a, obs, model_out());
            end
        end
        prog_we = 1'b0;
    endtask

    task automatic test_basic();
        logic [12:0] pulses = '0;
        prog_length = 5'd3;
        run = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (pixel_valid) pulses[i] = 1'b1;
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs, model_out());
            end
        end
        vectors++;
        if (pulses !== 13'h490) begin
            miscompares++;
            $display("FAIL basic_pulse_cycles got=%b exp=%b", pulses, 13'h490);
        end
        run = 1'b0;
        for (int g = 0; g < 20 && m_mode != 0; g++) begin
            tick();
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL basic_drain got=%h exp=%h", obs, model_out());
            end
        end
    endtask

    task automatic test_frame_wrap();
        logic [10:0] firsts = '0;
        logic [31:0] f_at9  = '0;
        do_reset();
        prog_length = 5'd1;
        run = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (frame_first && pixel_valid) firsts[i] = 1'b1;
            if (i == 9) f_at9 = f_number;
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", i, obs, model_out());
            end
        end
        vectors++;
        if (f_at9 !== 32'd1) begin
            miscompares++;
            $display("FAIL wrap_frame got=%0d exp=1", f_at9);
        end
        vectors++;
        if (firsts !== 11'h404) begin
            miscompares++;
            $display("FAIL wrap_first got=%b exp=%b", firsts, 11'h404);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        int          phase = 0;
        int          held  = 0;
        logic [31:0] x_frz = '0;
        prog_length = 5'd3;
        run = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < 40 && phase < 3; i++) begin
            tick();
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", i, obs, model_out());
            end
            if (phase == 0 && m_mode == 1 && m_step == 1) begin
                hold = 1'b1;
                phase = 1;
            end else if (phase == 1 && m_mode == 2) begin
                if (held == 0) x_frz = x_coord;
                vectors++;
                if (x_coord !== x_frz || instruction !== NOP) begin
                    miscompares++;
                    $display("FAIL hold_frozen x=%0d ins=%h exp x=%0d ins=%h", x_coord, instruction, x_frz, NOP);
                end
                held++;
                if (held == 3) begin
                    hold = 1'b0;
                    phase = 2;
                end
            end else if (phase == 2) begin
                vectors++;
                if (instruction !== m_mem[0] || x_coord !== x_frz) begin
                    miscompares++;
                    $display("FAIL hold_resume ins=%h x=%0d exp ins=%h x=%0d", instruction, x_coord, m_mem[0], x_frz);
                end
                phase = 3;
            end
        end
        vectors++;
        if (phase != 3) begin
            miscompares++;
            $display("FAIL hold_sequence got phase=%0d exp phase=3", phase);
        end
    endtask

    task automatic test_run_drop();
        int          n = 0;
        logic [31:0] x_stop;
        run = 1'b1;
        for (int g = 0; g < 10 && !(m_mode == 1 && m_step == 1); g++) tick();
        run = 1'b0;
        for (int g = 0; g < 10 && busy; g++) begin
            tick();
            n++;
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL rundrop got=%h exp=%h", obs, model_out());
            end
        end
        vectors++;
        if (n != 2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rundrop_busy_fall got=%0d cycles busy=%b exp=2 cycles busy=0", n, busy);
        end
        x_stop = x_coord;
        run = 1'b1;
        tick();
        vectors++;
        if (instruction !== m_mem[0] || x_coord !== x_stop || obs !== model_out()) begin
            miscompares++;
            $display("FAIL rundrop_resume got=%h exp=%h", obs, model_out());
        end
    endtask

    task automatic test_protect();
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_data = ~m_mem[0];
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL protect_we cyc=%0d got=%h exp=%h", i, obs, model_out());
            end
        end
        prog_we = 1'b0;
        run = 1'b0;
        for (int g = 0; g < 20 && m_mode != 0; g++) tick();
        prog_length = 5'd0;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || instruction !== NOP || obs !== model_out()) begin
                miscompares++;
                $display("FAIL protect_len0 got=%h exp=%h", obs, model_out());
            end
        end
        prog_length = 5'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL protect_readback got=%h exp=%h", obs, model_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            run       = ($urandom() % 8) != 0;
            hold      = ($urandom() % 4) == 0;
            prog_we   = ($urandom() % 3) == 0;
            prog_addr = 4'($urandom());
            prog_data = {14'($urandom()), $urandom()};
            if ($urandom() % 5 == 0) prog_length = 5'($urandom_range(0, 16));
            tick();
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, model_out());
            end
        end
        prog_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        run = 1'b0;
        hold = 1'b0;
        for (int g = 0; g < 40 && m_mode != 0; g++) tick();
        prog_length = 5'd4;
        run = 1'b1;
        for (int g = 0; g < 10 && !(m_mode == 1 && m_step == 2); g++) tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (pixel_valid !== 1'b0 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL reset_mid got=%h exp=%h", obs, model_out());
        end
        @(negedge clk);
        vectors++;
        if (obs !== model_out()) begin
            miscompares++;
            $display("FAIL reset_mid_hold got=%h exp=%h", obs, model_out());
        end
        reset_n = 1'b1;
        run = 1'b0;
        tick();
        vectors++;
        if (obs !== model_out()) begin
            miscompares++;
            $display("FAIL reset_mid_release got=%h exp=%h", obs, model_out());
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_basic();
        test_frame_wrap();
        test_hold();
        test_run_drop();
        test_protect();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
